// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM MEM-stage data memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arm_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   localparam int unsigned DEFAULT_BASE_ADDR = 32'd1024;
   localparam int          BYTE_W            = 8;

endpackage

// File: rtl/arm_data_memory_if.sv
// MEM-stage request/response bundle between the pipeline and the data memory.
// Latency: n/a (wires only).
// Backpressure: the slave raises stall until it pulses ready; the master holds its request meanwhile.
// Ports: master drives mem_read/mem_write/byte_mode/address/wdata; slave returns rdata/ready/stall/addr_err.
interface arm_data_memory_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  mem_read;
   logic                  mem_write;
   logic                  byte_mode;
   logic [31:0]           address;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  ready;
   logic                  stall;
   logic                  addr_err;

   modport master (
      output mem_read, mem_write, byte_mode, address, wdata,
      input  rdata, ready, stall, addr_err
   );

   modport slave (
      input  mem_read, mem_write, byte_mode, address, wdata,
      output rdata, ready, stall, addr_err
   );
endinterface

// File: rtl/arm_mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_WIDTH, per-byte write enables, registered read.
// Latency: read data appears the cycle after re_i; writes land on the enabling edge.
// Backpressure: none; accepts one operation per cycle.
// Ports: clk, idx_i word index, be_i byte enables, wdata_i, re_i read enable, rdata_o read register.
module arm_mem_array
   import arm_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4096,
   parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int NB         = DATA_WIDTH / BYTE_W
) (
   input  logic                  clk,
   input  logic [AW-1:0]         idx_i,
   input  logic [NB-1:0]         be_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_q;

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (be_i[b]) begin
            mem_q[idx_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
         end
      end
      if (re_i) begin
         rd_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rd_q;

endmodule

// File: rtl/arm_data_memory.sv
// Multi-cycle, stall-aware data memory for the ARM MEM stage (word/byte access, range check).
// Latency: ready pulses WAIT_CYCLES+1 cycles after the acceptance edge; one access per WAIT_CYCLES+2 cycles.
// Backpressure: stall = request & ~ready; the request is latched on acceptance so later input changes are ignored.
// Ports: clk, rst (sync, active-high), bus (slave side of arm_data_memory_if).
module arm_data_memory
   import arm_mem_pkg::*;
#(
   parameter int          DATA_WIDTH  = 32,
   parameter int          DEPTH       = 4096,
   parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   arm_data_memory_if.slave  bus
);

   localparam int NB = DATA_WIDTH / BYTE_W;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   mem_state_t            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  rd_q, wr_q, bm_q;
   logic [31:0]           addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  err_q;
   logic                  rzero_q, rbyte_q;
   logic [1:0]            rlane_q;

   logic                  req, idle, go_done;
   logic                  acc_rd, acc_wr, acc_bm;
   logic [31:0]           acc_addr, widx32;
   logic [DATA_WIDTH-1:0] acc_wdata, arr_wdata, dout;
   logic                  oor, we, re;
   logic [NB-1:0]         be, be_byte;
   logic [BYTE_W-1:0]     lane_byte;

   assign req  = bus.mem_read | bus.mem_write;
   assign idle = (state_q == IDLE);

   // With zero wait states DONE is entered straight from IDLE, before the
   // latches are loaded, so the live inputs describe the access on that edge.
   assign acc_rd    = idle ? bus.mem_read  : rd_q;
   assign acc_wr    = idle ? bus.mem_write : wr_q;
   assign acc_bm    = idle ? bus.byte_mode : bm_q;
   assign acc_addr  = idle ? bus.address   : addr_q;
   assign acc_wdata = idle ? bus.wdata     : wdata_q;

   assign widx32 = (acc_addr - 32'(BASE_ADDR)) >> 2;
   assign oor    = (acc_addr < 32'(BASE_ADDR)) || (widx32 >= 32'(DEPTH));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               cnt_d   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
               state_d = (WAIT_CYCLES > 0) ? WAIT : DONE;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // DONE is only ever entered from IDLE or WAIT, so this is the commit edge.
   assign go_done = (state_d == DONE) & ~rst;

   // A simultaneous read+write is a write; out-of-range accesses touch nothing.
   assign we      = go_done & acc_wr & ~oor;
   assign re      = go_done & acc_rd & ~acc_wr & ~oor;
   assign be_byte = {{(NB-1){1'b0}}, 1'b1} << acc_addr[1:0];
   assign be      = we ? (acc_bm ? be_byte : {NB{1'b1}}) : {NB{1'b0}};
   assign arr_wdata = acc_bm ? {NB{acc_wdata[BYTE_W-1:0]}} : acc_wdata;

   arm_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW),
      .NB         (NB)
   ) u_array (
      .clk     (clk),
      .idx_i   (widx32[AW-1:0]),
      .be_i    (be),
      .wdata_i (arr_wdata),
      .re_i    (re),
      .rdata_o (dout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         bm_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rzero_q <= 1'b1;
         rbyte_q <= 1'b0;
         rlane_q <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (idle && req) begin
            rd_q    <= bus.mem_read;
            wr_q    <= bus.mem_write;
            bm_q    <= bus.byte_mode;
            addr_q  <= bus.address;
            wdata_q <= bus.wdata;
         end
         if (go_done) begin
            err_q <= oor;
         end
         // The view of the read register only changes on a load or a range error,
         // so rdata holds across writes and idle cycles.
         if (go_done && oor) begin
            rzero_q <= 1'b1;
         end else if (re) begin
            rzero_q <= 1'b0;
            rbyte_q <= acc_bm;
            rlane_q <= acc_addr[1:0];
         end
      end
   end

   assign lane_byte    = dout[{rlane_q, 3'b000} +: BYTE_W];
   assign bus.rdata    = rzero_q ? '0 :
                         (rbyte_q ? {{(DATA_WIDTH-BYTE_W){1'b0}}, lane_byte} : dout);
   assign bus.ready    = (state_q == DONE);
   assign bus.addr_err = (state_q == DONE) & err_q;
   assign bus.stall    = req & ~bus.ready;

endmodule

// File: tb/tb_arm_data_memory.sv
// Bench for arm_data_memory: two instances (2 wait states / depth 4096, 0 wait states / depth 64).
// Latency: each access is checked against WAIT_CYCLES+1 cycles from acceptance.
// Backpressure: requests are held until ready, then replaced or dropped.
module tb_arm_data_memory;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   arm_data_memory_if #(.DATA_WIDTH(32)) bus0 ();
   arm_data_memory_if #(.DATA_WIDTH(32)) bus1 ();

   arm_data_memory #(.DATA_WIDTH(32), .DEPTH(4096), .BASE_ADDR(1024), .WAIT_CYCLES(2))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));
   arm_data_memory #(.DATA_WIDTH(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));

   logic        rd_s [2];
   logic        wr_s [2];
   logic        bm_s [2];
   logic [31:0] ad_s [2];
   logic [31:0] wd_s [2];
   logic [31:0] rdata_w [2];
   logic        ready_w [2];
   logic        stall_w [2];
   logic        err_w [2];

   assign bus0.mem_read = rd_s[0];  assign bus1.mem_read = rd_s[1];
   assign bus0.mem_write = wr_s[0]; assign bus1.mem_write = wr_s[1];
   assign bus0.byte_mode = bm_s[0]; assign bus1.byte_mode = bm_s[1];
   assign bus0.address = ad_s[0];   assign bus1.address = ad_s[1];
   assign bus0.wdata = wd_s[0];     assign bus1.wdata = wd_s[1];
   assign rdata_w[0] = bus0.rdata;  assign rdata_w[1] = bus1.rdata;
   assign ready_w[0] = bus0.ready;  assign ready_w[1] = bus1.ready;
   assign stall_w[0] = bus0.stall;  assign stall_w[1] = bus1.stall;
   assign err_w[0] = bus0.addr_err; assign err_w[1] = bus1.addr_err;

   int total = 0;
   int bad   = 0;

   // Reference model: byte-addressed contents (only bytes ever stored exist)
   // and the expected value of rdata per instance.
   logic [7:0]  mdl [int];
   logic [31:0] exp_rd [2];
   bit          exp_ok [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int wait_of(input int sel);
      return (sel == 0) ? 2 : 0;
   endfunction

   function automatic int depth_of(input int sel);
      return (sel == 0) ? 4096 : 64;
   endfunction

   function automatic int key(input int sel, input logic [31:0] off);
      return (sel << 16) | int'(off);
   endfunction

   task automatic release_req();
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
         rd_s[s] = 1'b0; wr_s[s] = 1'b0; bm_s[s] = 1'b0;
      end
   endtask

   // Issues one access in the next IDLE cycle and checks handshake, latency,
   // addr_err and rdata. Returns at the DONE cycle with the request still driven.
   task automatic access(input int sel, input bit rd, input bit wr, input bit bm,
                         input logic [31:0] a, input logic [31:0] wd);
      bit          oor, done;
      int          n;
      logic [31:0] off, wbase;
      oor   = (a < 32'd1024) || (((a - 32'd1024) >> 2) >= 32'(depth_of(sel)));
      off   = a - 32'd1024;
      wbase = {off[31:2], 2'b00};
      if (oor) begin
         if (wr) exp_ok[sel] = 1'b0;
         else begin exp_rd[sel] = 32'd0; exp_ok[sel] = 1'b1; end
      end else if (wr) begin
         if (bm) mdl[key(sel, off)] = wd[7:0];
         else for (int b = 0; b < 4; b++) mdl[key(sel, wbase + 32'(b))] = wd[8*b +: 8];
      end else if (bm) begin
         exp_ok[sel] = mdl.exists(key(sel, off));
         if (exp_ok[sel]) exp_rd[sel] = {24'd0, mdl[key(sel, off)]};
      end else begin
         exp_ok[sel] = 1'b1;
         for (int b = 0; b < 4; b++) begin
            if (mdl.exists(key(sel, wbase + 32'(b)))) exp_rd[sel][8*b +: 8] = mdl[key(sel, wbase + 32'(b))];
            else exp_ok[sel] = 1'b0;
         end
      end

      @(posedge clk); #1;
      rd_s[sel] = rd; wr_s[sel] = wr; bm_s[sel] = bm; ad_s[sel] = a; wd_s[sel] = wd;
      n = 0; done = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         if (ready_w[sel]) done = 1;
         else begin
            chk("stall_wait", {31'd0, stall_w[sel]}, 32'd1);
            n++;
         end
      end
      if (!done) chk("ready_timeout", 32'd0, 32'd1);
      else begin
         chk("latency", n, wait_of(sel) + 1);
         chk("stall_done", {31'd0, stall_w[sel]}, 32'd0);
         chk("addr_err", {31'd0, err_w[sel]}, {31'd0, oor});
         if (exp_ok[sel]) chk("rdata", rdata_w[sel], exp_rd[sel]);
      end
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         rd_s[s] = 0; wr_s[s] = 0; bm_s[s] = 0; ad_s[s] = 0; wd_s[s] = 0;
         exp_rd[s] = 32'd0; exp_ok[s] = 1'b1;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("rst_rdata", rdata_w[s], 32'd0);
         chk("rst_ready", {31'd0, ready_w[s]}, 32'd0);
         chk("rst_err", {31'd0, err_w[s]}, 32'd0);
         chk("rst_stall", {31'd0, stall_w[s]}, 32'd0);
      end

      // Word write then read back.
      access(0, 0, 1, 0, 32'd1024, 32'h12345678);
      access(0, 1, 0, 0, 32'd1024, 32'h0);
      chk("tp_word", rdata_w[0], 32'h12345678);
      // Byte store into lane 2, then word and byte reads.
      access(0, 0, 1, 1, 32'd1026, 32'hFFFFFFAB);
      access(0, 1, 0, 0, 32'd1024, 32'h0);
      chk("tp_merge", rdata_w[0], 32'h12AB5678);
      access(0, 1, 0, 1, 32'd1026, 32'h0);
      chk("tp_byte", rdata_w[0], 32'h000000AB);
      // Out of range below and above.
      access(0, 1, 0, 0, 32'd1020, 32'h0);
      chk("tp_oor_lo", rdata_w[0], 32'd0);
      access(0, 0, 1, 0, 32'd1024 + 32'd16384, 32'hCAFEF00D);
      chk("tp_oor_hi", rdata_w[0], 32'd0);
      access(0, 1, 0, 0, 32'd1024, 32'h0);
      chk("tp_oor_keep", rdata_w[0], 32'h12AB5678);
      release_req();

      // Zero wait states, back-to-back reads.
      access(1, 0, 1, 0, 32'd1024, 32'hA5A50001);
      access(1, 0, 1, 0, 32'd1028, 32'h5A5A0002);
      access(1, 1, 0, 0, 32'd1024, 32'h0);
      chk("tp_b2b_0", rdata_w[1], 32'hA5A50001);
      access(1, 1, 0, 0, 32'd1028, 32'h0);
      chk("tp_b2b_1", rdata_w[1], 32'h5A5A0002);
      release_req();

      // Reset while a write waits: nothing is committed.
      access(0, 0, 1, 0, 32'd1032, 32'h11112222);
      @(posedge clk); #1;
      rd_s[0] = 0; wr_s[0] = 1; bm_s[0] = 0; ad_s[0] = 32'd1032; wd_s[0] = 32'hDEADBEEF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; wr_s[0] = 0;
      for (int s = 0; s < 2; s++) begin rd_s[s] = 0; wr_s[s] = 0; end
      @(negedge clk);
      chk("rst_mid_ready", {31'd0, ready_w[0]}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("post_rst_ready", {31'd0, ready_w[0]}, 32'd0);
         chk("post_rst_rdata", rdata_w[0], 32'd0);
         chk("post_rst_err", {31'd0, err_w[0]}, 32'd0);
         chk("post_rst_stall", {31'd0, stall_w[0]}, 32'd0);
      end
      for (int s = 0; s < 2; s++) begin exp_rd[s] = 32'd0; exp_ok[s] = 1'b1; end
      access(0, 1, 0, 0, 32'd1032, 32'h0);
      chk("tp_rst_old", rdata_w[0], 32'h11112222);

      // Simultaneous read and write is a write with rdata held.
      access(0, 1, 1, 0, 32'd1036, 32'h5);
      chk("tp_both_hold", rdata_w[0], 32'h11112222);
      access(0, 1, 0, 0, 32'd1036, 32'h0);
      chk("tp_both_wr", rdata_w[0], 32'h5);
      release_req();

      // Randomized traffic on both instances.
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 120; i++) begin
            int          op, r;
            logic [31:0] a;
            op = $urandom_range(0, 2);
            r  = $urandom_range(0, 9);
            if (r == 0)      a = 32'd1024 - 32'($urandom_range(1, 32));
            else if (r == 1) a = 32'd1024 + 32'(depth_of(s) * 4) + 32'($urandom_range(0, 63));
            else             a = 32'd1024 + 32'($urandom_range(0, 63));
            access(s, op != 1, op != 0, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 1) == 1) release_req();
         end
         release_req();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
